// File: rtl/bist_scan_top.sv
`timescale 1ns/1ps
// bist_scan_top: scan-based BIST around a small 8-bit sequential CUT.
// LFSR patterns are scanned in and captured, and the responses are compacted into a MISR signature.
module bist_scan_top #(
  parameter int unsigned SCAN_LEN   = 8,
  parameter int unsigned N_PATTERNS = 1000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bist_start,
  input  logic [3:0] pi,
  output logic       bist_end,
  output logic       pass_nfail,
  output logic [3:0] po
);

  localparam int SHIFT_W = $clog2(SCAN_LEN + 1);
  localparam int PAT_W   = $clog2(N_PATTERNS + 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]         cut_state;
  logic [15:0]        lfsr;
  logic [15:0]        misr;
  logic [15:0]        misr_in;
  logic               misr_en;
  logic [SHIFT_W-1:0] shift_cnt;
  logic [PAT_W-1:0]   pat_cnt;
  logic               start_q;
  logic               start_edge;
  logic               scan_in;
  logic               scan_out;
  logic [3:0]         cut_cin;
  logic               shift_last;
  logic               pat_last;

  // start_q resets high so a request level held across reset release is not an edge
  assign start_edge = bist_start & ~start_q;
  assign scan_out   = cut_state[7];
  assign scan_in    = (state == SHIFT) ? lfsr[15] : 1'b0;
  assign cut_cin    = (state == CAPTURE) ? lfsr[3:0] : pi;
  assign po         = cut_state[7:4] ^ cut_state[3:0];
  assign shift_last = (shift_cnt == SHIFT_W'(SCAN_LEN - 1));
  assign pat_last   = (pat_cnt == PAT_W'(N_PATTERNS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b1;
    end else begin
      state   <= next_state;
      start_q <= bist_start;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_edge) next_state = INIT;
      INIT:       next_state = SHIFT;
      SHIFT:      if (shift_last) next_state = CAPTURE;
      CAPTURE:    next_state = pat_last ? UNLOAD : SHIFT;
      UNLOAD:     if (shift_last) next_state = COMPARE;
      COMPARE:    next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    misr_in = 16'h0000;
    misr_en = 1'b0;
    case (state)
      SHIFT, UNLOAD: begin
        misr_in = {15'd0, scan_out};
        misr_en = 1'b1;
      end
      CAPTURE: begin
        misr_in = {12'd0, po};
        misr_en = 1'b1;
      end
      default: begin
        misr_in = 16'h0000;
        misr_en = 1'b0;
      end
    endcase
  end

  // CUT runs functionally from pi in idle/done and from the LFSR on capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cut_state <= 8'h00;
    end else begin
      case (state)
        INIT:          cut_state <= 8'h00;
        SHIFT, UNLOAD: cut_state <= {cut_state[6:0], scan_in};
        COMPARE:       cut_state <= cut_state;
        default:       cut_state <= {cut_state[7:4] ^ cut_state[3:0],
                                     cut_state[3:0] + cut_cin};
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (state == INIT) begin
      lfsr <= LFSR_SEED;
    end else if (state == SHIFT) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misr <= 16'h0000;
    end else if (state == INIT) begin
      misr <= 16'h0000;
    end else if (misr_en) begin
      misr <= {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ misr_in;
    end
  end

  // shift_cnt wraps at the end of every SHIFT/UNLOAD burst so UNLOAD starts from zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_cnt <= '0;
      pat_cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          shift_cnt <= '0;
          pat_cnt   <= '0;
        end
        SHIFT, UNLOAD: shift_cnt <= shift_last ? '0 : shift_cnt + 1'b1;
        CAPTURE:       pat_cnt   <= pat_cnt + 1'b1;
        default: begin
          shift_cnt <= shift_cnt;
          pat_cnt   <= pat_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
    end else if (state == INIT) begin
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
    end else if (state == COMPARE) begin
      bist_end   <= 1'b1;
      pass_nfail <= (misr == GOLDEN_SIG);
    end
  end

endmodule

// File: tb/tb_bist_scan_top.sv
`timescale 1ns/1ps
// tb_bist_scan_top: self-checking bench for bist_scan_top. The golden signature
// comes from a loop-level model of the test sequence; functional mode uses a small CUT model.
module tb_bist_scan_top;

  localparam int          SCAN_LEN     = 8;
  localparam int          N_PATTERNS   = 1000;
  localparam logic [15:0] SEED         = 16'hACE1;
  localparam int          RUN_CYCLES   = 1 + N_PATTERNS * (SCAN_LEN + 1) + SCAN_LEN + 1;
  localparam int          CYCLE_BUDGET = 9200;
  localparam int          NVEC         = 12;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] v);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ v;
  endfunction

  // Whole-sequence signature; stuck_bit >= 0 models that CUT bit held at 0
  function automatic logic [15:0] model_signature(input int stuck_bit);
    logic [15:0] l;
    logic [15:0] m;
    logic [7:0]  s;
    logic [7:0]  keep;
    l = SEED;
    m = 16'h0000;
    s = 8'h00;
    keep = 8'hFF;
    if (stuck_bit >= 0) keep = ~(8'd1 << stuck_bit);
    for (int pa = 0; pa < 10; pa++) begin
      for (int pb = 0; pb < N_PATTERNS / 10; pb++) begin
        for (int i = 0; i < SCAN_LEN; i++) begin
          m = misr_step(m, {15'd0, s[7]});
          s = {s[6:0], l[15]} & keep;
          l = lfsr_step(l);
        end
        m = misr_step(m, {12'd0, s[7:4] ^ s[3:0]});
        s = {s[7:4] ^ s[3:0], s[3:0] + l[3:0]} & keep;
      end
    end
    for (int i = 0; i < SCAN_LEN; i++) begin
      m = misr_step(m, {15'd0, s[7]});
      s = {s[6:0], 1'b0} & keep;
    end
    return m;
  endfunction

  localparam logic [15:0] GOLDEN = model_signature(-1);

  logic       clock = 1'b0;
  logic       reset;
  logic       bist_start;
  logic [3:0] pi;
  logic       bist_end;
  logic       pass_nfail;
  logic [3:0] po;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] pi;
    logic [3:0] exp_po;
  } vec_t;

  vec_t vecs[NVEC];

  bist_scan_top #(
    .SCAN_LEN  (SCAN_LEN),
    .N_PATTERNS(N_PATTERNS),
    .LFSR_SEED (SEED),
    .GOLDEN_SIG(GOLDEN)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bist_start(bist_start),
    .pi        (pi),
    .bist_end  (bist_end),
    .pass_nfail(pass_nfail),
    .po        (po)
  );

  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Functional CUT from s=0: lo accumulates pi, hi accumulates the previous lo
  task automatic build_vectors();
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] lo_old;
    lo = 4'h0;
    hi = 4'h0;
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].pi = (i < 2) ? 4'h3 : 4'($urandom_range(0, 15));
      lo_old = lo;
      lo = lo + vecs[i].pi;
      hi = hi ^ lo_old;
      vecs[i].exp_po = hi ^ lo;
    end
  endtask

  task automatic applyStimulus(input int idx);
    pi = vecs[idx].pi;
    @(posedge clock);
    #1;
  endtask

  task automatic run_vectors(input string tag, input logic exp_end, input logic exp_pass);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i);
      checkOutput($sformatf("%s_po%0d", tag, i), 16'(po), 16'(vecs[i].exp_po));
    end
    checkOutput({tag, "_end"}, 16'(bist_end), 16'(exp_end));
    checkOutput({tag, "_pass"}, 16'(pass_nfail), 16'(exp_pass));
    pi = 4'h0;
  endtask

  // c counts rising edges from the one that samples the start edge (c=0)
  task automatic run_sequence(input int pulse_len, input int extra_at, input int extra_len,
                              output int end_cycle, output logic low_ok);
    bist_start = 1'b1;
    end_cycle = -1;
    low_ok = 1'b0;
    for (int c = 0; c <= CYCLE_BUDGET; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) low_ok = (bist_end == 1'b0) && (pass_nfail == 1'b0);
      if (c >= 1 && bist_end) begin
        end_cycle = c;
        break;
      end
      if (c == pulse_len - 1) bist_start = 1'b0;
      if (extra_len > 0 && c == extra_at - 1) bist_start = 1'b1;
      if (extra_len > 0 && c == extra_at + extra_len - 1) bist_start = 1'b0;
    end
    bist_start = 1'b0;
  endtask

  initial begin
    int          end_cycle;
    logic        low_ok;
    logic [15:0] fault_sig;

    build_vectors();
    reset = 1'b0;
    bist_start = 1'b0;
    pi = 4'h0;
    $display("[TB] golden signature %04h", GOLDEN);

    repeat (20) @(posedge clock);
    #1;
    checkOutput("reset_po", 16'(po), 16'd0);
    checkOutput("reset_end", 16'(bist_end), 16'd0);
    checkOutput("reset_pass", 16'(pass_nfail), 16'd0);
    reset = 1'b1;

    run_vectors("idle", 1'b0, 1'b0);

    @(posedge clock);
    #1;
    run_sequence(10, 0, 0, end_cycle, low_ok);
    checkInt("run1_len", end_cycle, RUN_CYCLES);
    checkOutput("run1_low", 16'(low_ok), 16'd1);
    checkOutput("run1_pass", 16'(pass_nfail), 16'd1);
    checkOutput("done_po", 16'(po), 16'd0);
    run_vectors("done", 1'b1, 1'b1);

    @(posedge clock);
    #1;
    run_sequence(40, 90, 5, end_cycle, low_ok);
    checkInt("restart_len", end_cycle, RUN_CYCLES);
    checkOutput("restart_low", 16'(low_ok), 16'd1);
    checkOutput("restart_pass", 16'(pass_nfail), 16'd1);

    bist_start = 1'b1;
    repeat (3000 + $urandom_range(0, 2000)) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_end", 16'(bist_end), 16'd0);
    checkOutput("abort_pass", 16'(pass_nfail), 16'd0);
    checkOutput("abort_po", 16'(po), 16'd0);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    run_vectors("abort_hold", 1'b0, 1'b0);
    bist_start = 1'b0;
    @(posedge clock);
    #1;
    run_sequence(1, 0, 0, end_cycle, low_ok);
    checkInt("abort_rerun_len", end_cycle, RUN_CYCLES);
    checkOutput("abort_rerun_pass", 16'(pass_nfail), 16'd1);

    reset = 1'b0;
    @(posedge clock);
    #1;
    bist_start = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("rst_edge_end", 16'(bist_end), 16'd0);
    checkOutput("rst_edge_po", 16'(po), 16'd0);
    reset = 1'b1;
    run_vectors("rst_edge", 1'b0, 1'b0);
    bist_start = 1'b0;
    @(posedge clock);
    #1;
    run_sequence(3, 0, 0, end_cycle, low_ok);
    checkInt("rst_edge_run_len", end_cycle, RUN_CYCLES);
    checkOutput("rst_edge_run_pass", 16'(pass_nfail), 16'd1);

    fault_sig = model_signature(5);
    force dut.cut_state[5] = 1'b0;
    @(posedge clock);
    #1;
    run_sequence(2, 0, 0, end_cycle, low_ok);
    checkInt("fault_len", end_cycle, RUN_CYCLES);
    checkOutput("fault_low", 16'(low_ok), 16'd1);
    checkOutput("fault_pass", 16'(pass_nfail), 16'(fault_sig == GOLDEN));
    release dut.cut_state[5];

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
